// File: rtl/uf_stage_controller.sv
// uf_stage_controller
// Global sequencer for the union-find decoder PE array. It broadcasts the
// current stage code to every PE, watches the aggregated busy/odd flags and
// runs one decode round:
//   load -> MERGE -> (GROW -> MERGE)* -> PEELING -> result handshake.
// The optional round-latency counter on cycle_count_o is built only when the
// macro UF_CYCLE_COUNTER_EN is defined; otherwise cycle_count_o is tied to 0.

module uf_stage_controller #(
    parameter int PU_COUNT         = 64,
    parameter int STAGE_WIDTH      = 3,
    parameter int MIN_MERGE_CYCLES = 4,
    parameter int MAX_MERGE_CYCLES = 255,
    parameter int MAX_ITERATIONS   = 31,
    parameter int PEEL_CYCLES      = 8,
    parameter int ITER_WIDTH       = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   meas_valid_i,
    output logic                   meas_ready_o,
    input  logic [PU_COUNT-1:0]    busy_i,
    input  logic [PU_COUNT-1:0]    odd_i,
    output logic [STAGE_WIDTH-1:0] global_stage_o,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [ITER_WIDTH-1:0]  iteration_count_o,
    output logic                   error_o,
    output logic [31:0]            cycle_count_o
);

    // Stage codes; the state register itself is broadcast to the PEs.
    localparam logic [STAGE_WIDTH-1:0] ST_IDLE    = STAGE_WIDTH'(0);
    localparam logic [STAGE_WIDTH-1:0] ST_GROW    = STAGE_WIDTH'(1);
    localparam logic [STAGE_WIDTH-1:0] ST_MERGE   = STAGE_WIDTH'(2);
    localparam logic [STAGE_WIDTH-1:0] ST_PEELING = STAGE_WIDTH'(3);
    localparam logic [STAGE_WIDTH-1:0] ST_RESULT  = STAGE_WIDTH'(4);
    localparam logic [STAGE_WIDTH-1:0] ST_LOAD    = STAGE_WIDTH'(5);

    // Measurement loading lasts two cycles so the PEs, which see the stage
    // one cycle late, still get a full loading cycle.
    localparam int LOAD_CYCLES = 2;

    // One phase counter serves both fixed-length stages (LOAD and PEELING).
    localparam int PHASE_MAX  = (PEEL_CYCLES > LOAD_CYCLES) ? PEEL_CYCLES : LOAD_CYCLES;
    localparam int PHASE_W    = $clog2(PHASE_MAX + 1);
    localparam int MERGE_W    = $clog2(MAX_MERGE_CYCLES + 1);
    localparam int MERGE_EXIT = (MIN_MERGE_CYCLES > 0) ? MIN_MERGE_CYCLES - 1 : 0;

    localparam logic [PHASE_W-1:0]    LOAD_LAST   = PHASE_W'(LOAD_CYCLES - 1);
    localparam logic [PHASE_W-1:0]    PEEL_LAST   = PHASE_W'(PEEL_CYCLES - 1);
    localparam logic [MERGE_W-1:0]    MERGE_MIN   = MERGE_W'(MERGE_EXIT);
    localparam logic [MERGE_W-1:0]    MERGE_LIMIT = MERGE_W'(MAX_MERGE_CYCLES);
    localparam logic [ITER_WIDTH-1:0] ITER_LIMIT  = ITER_WIDTH'(MAX_ITERATIONS);

    // Quiet cycles only matter up to two, so the counter saturates at 2.
    localparam logic [1:0] QUIET_NEEDED = 2'd2;

    logic [STAGE_WIDTH-1:0] state_q, state_d;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [MERGE_W-1:0]     merge_q, merge_d;
    logic [1:0]             quiet_q, quiet_d;
    logic [ITER_WIDTH-1:0]  iter_q, iter_d;
    logic                   error_q, error_d;
    logic                   meas_ready_q, meas_ready_d;
    logic                   result_valid_q, result_valid_d;

    logic                   accept;
    logic                   any_busy;
    logic                   any_odd;
    logic [1:0]             quiet_now;
    logic                   merge_exit;

    // Round acceptance and the MERGE exit condition. Busy in the current
    // cycle always wins over an otherwise complete quiet run.
    always_comb begin
        accept     = (state_q == ST_IDLE) && meas_valid_i && meas_ready_q;
        any_busy   = |busy_i;
        any_odd    = |odd_i;
        quiet_now  = any_busy ? 2'd0 :
                     (quiet_q == QUIET_NEEDED) ? QUIET_NEEDED : quiet_q + 2'd1;
        merge_exit = (merge_q >= MERGE_MIN) && (quiet_now >= QUIET_NEEDED);
    end

    // Next-state logic for the stage sequencer and its counters.
    // NOTE: every signal gets its hold value first, so no branch can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        merge_d = merge_q;
        quiet_d = quiet_q;
        iter_d  = iter_q;
        error_d = error_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                    phase_d = '0;
                    merge_d = '0;
                    quiet_d = '0;
                    iter_d  = '0;
                    error_d = 1'b0;
                end
            end

            ST_LOAD: begin
                if (phase_q == LOAD_LAST) begin
                    // Start with MERGE so the first odd flags are clean.
                    state_d = ST_MERGE;
                    phase_d = '0;
                    merge_d = '0;
                    quiet_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            ST_MERGE: begin
                quiet_d = quiet_now;
                if (merge_q != MERGE_LIMIT) begin
                    merge_d = merge_q + 1'b1;
                end
                if (merge_exit) begin
                    merge_d = '0;
                    quiet_d = '0;
                    if (any_odd) begin
                        if (iter_q == ITER_LIMIT) begin
                            state_d = ST_RESULT;
                            error_d = 1'b1;
                        end else begin
                            state_d = ST_GROW;
                        end
                    end else begin
                        state_d = ST_PEELING;
                        phase_d = '0;
                    end
                end else if (merge_q == MERGE_LIMIT) begin
                    // Watchdog: the array never settled.
                    state_d = ST_RESULT;
                    error_d = 1'b1;
                end
            end

            ST_GROW: begin
                // Single cycle; the PEs fire their increase on this edge.
                iter_d  = iter_q + 1'b1;
                state_d = ST_MERGE;
                merge_d = '0;
                quiet_d = '0;
            end

            ST_PEELING: begin
                if (phase_q == PEEL_LAST) begin
                    state_d = ST_RESULT;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            ST_RESULT: begin
                if (result_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next state.
        meas_ready_d   = (state_d == ST_IDLE);
        result_valid_d = (state_d == ST_RESULT);
    end

    // Sequencer registers with synchronous active-low reset.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only; there are no memories
        // here, so every register returns to a known value.
        if (!reset) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            merge_q        <= '0;
            quiet_q        <= '0;
            iter_q         <= '0;
            error_q        <= 1'b0;
            meas_ready_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            merge_q        <= merge_d;
            quiet_q        <= quiet_d;
            iter_q         <= iter_d;
            error_q        <= error_d;
            meas_ready_q   <= meas_ready_d;
            result_valid_q <= result_valid_d;
        end
    end

`ifdef UF_CYCLE_COUNTER_EN
    logic [31:0] cycle_q, cycle_d;

    // Round latency: cleared on acceptance, counts every active-stage cycle,
    // saturates, and holds through RESULT_VALID and IDLE.
    always_comb begin
        cycle_d = cycle_q;
        if (accept) begin
            cycle_d = '0;
        end else if ((state_q != ST_IDLE) && (state_q != ST_RESULT) && (cycle_q != '1)) begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    // Latency counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_count_o = cycle_q;
`else
    assign cycle_count_o = '0;
`endif

    assign global_stage_o    = state_q;
    assign meas_ready_o      = meas_ready_q;
    assign result_valid_o    = result_valid_q;
    assign iteration_count_o = iter_q;
    assign error_o           = error_q;

endmodule

// File: tb/tb_uf_stage_controller.sv
// tb_uf_stage_controller
// Self-checking bench for uf_stage_controller. Each round is planned up front
// as a list of expected stages (one entry per cycle) computed from the round
// rules: how long each MERGE lasts given the busy pattern, whether odd forces
// another GROW, and the fixed LOAD/PEELING lengths. The busy/odd stimulus is
// taken from the same plan; a compare process checks every output each cycle.

module tb_uf_stage_controller;

    localparam int PU_COUNT  = 64;
    localparam int STAGE_W   = 3;
    localparam int MIN_MERGE = 4;
    localparam int MAX_MERGE = 255;
    localparam int MAX_ITER  = 31;
    localparam int PEEL      = 8;
    localparam int ITER_W    = 5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GROW  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_PEEL  = 3'd3;
    localparam logic [2:0] S_RV    = 3'd4;
    localparam logic [2:0] S_LOAD  = 3'd5;

`ifdef UF_CYCLE_COUNTER_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 meas_valid;
    logic                 meas_ready;
    logic [PU_COUNT-1:0]  busy;
    logic [PU_COUNT-1:0]  odd;
    logic [STAGE_W-1:0]   global_stage;
    logic                 result_valid;
    logic                 result_ready;
    logic [ITER_W-1:0]    iteration_count;
    logic                 error;
    logic [31:0]          cycle_count;

    uf_stage_controller #(
        .PU_COUNT        (PU_COUNT),
        .STAGE_WIDTH     (STAGE_W),
        .MIN_MERGE_CYCLES(MIN_MERGE),
        .MAX_MERGE_CYCLES(MAX_MERGE),
        .MAX_ITERATIONS  (MAX_ITER),
        .PEEL_CYCLES     (PEEL),
        .ITER_WIDTH      (ITER_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .meas_valid_i     (meas_valid),
        .meas_ready_o     (meas_ready),
        .busy_i           (busy),
        .odd_i            (odd),
        .global_stage_o   (global_stage),
        .result_valid_o   (result_valid),
        .result_ready_i   (result_ready),
        .iteration_count_o(iteration_count),
        .error_o          (error),
        .cycle_count_o    (cycle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected outputs for the current cycle.
    logic [2:0]        e_stage;
    logic              e_ready, e_rv, e_err;
    logic [ITER_W-1:0] e_iter;
    logic [31:0]       e_cyc;
    bit                exp_valid = 1'b0;

    // Compare process: outputs are stable between edges; sample at negedge.
    always @(negedge clk) begin
        if (exp_valid) begin
            check("global_stage", 64'(global_stage), 64'(e_stage));
            check("meas_ready", 64'(meas_ready), 64'(e_ready));
            check("result_valid", 64'(result_valid), 64'(e_rv));
            check("iteration_count", 64'(iteration_count), 64'(e_iter));
            check("error", 64'(error), 64'(e_err));
            check("cycle_count", 64'(cycle_count), 64'(e_cyc));
        end
    end

    // Reference model of the architectural outputs.
    int m_iter = 0;
    int m_cyc  = 0;
    bit m_err  = 1'b0;
    bit m_rdy_ok = 1'b0;   // last edge was not a reset edge

    typedef struct {
        logic [2:0]  stage;
        logic [63:0] busy;
        logic [63:0] odd;
    } cyc_t;

    cyc_t        tl[$];
    bit          tl_abort;
    int          tl_grows;
    logic [63:0] force_busy = '0;

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] nz64();
        logic [63:0] v;
        if ($urandom_range(1, 0) == 1) v = 64'h1 << $urandom_range(63, 0);
        else v = rnd64();
        if (v == 64'h0) v = 64'h1;
        return v;
    endfunction

    function automatic void push(input logic [2:0] st, input logic [63:0] b, input logic [63:0] o);
        cyc_t c;
        c.stage = st;
        c.busy  = b;
        c.odd   = o;
        tl.push_back(c);
    endfunction

    // Plan one round. n_odd MERGE phases end with odd != 0; the first MERGE is
    // busy for busy_len0 cycles; later ones get random busy runs/blips when
    // rand_busy is set; busy_stuck keeps busy high forever.
    function automatic void build_round(input int n_odd, input int busy_len0,
                                        input bit rand_busy, input bit busy_stuck);
        int          m;
        int          blen;
        logic [15:0] blip;
        logic [63:0] oddv;
        bit          prev_b, cur_b, done, wd;
        tl.delete();
        tl_abort = 1'b0;
        tl_grows = 0;
        repeat (2) push(S_LOAD, rnd64(), rnd64());
        m = 0;
        while (1) begin
            blen = (m == 0) ? busy_len0 : (rand_busy ? int'($urandom_range(7, 0)) : 0);
            blip = rand_busy ? 16'($urandom & $urandom) : 16'h0;
            oddv = (m < n_odd) ? nz64() : 64'h0;
            prev_b = 1'b0;
            done   = 1'b0;
            wd     = 1'b0;
            for (int k = 0; !done && !wd; k++) begin
                cur_b = busy_stuck || (k < blen) || ((k < 16) && blip[k % 16]);
                push(S_MERGE, cur_b ? ((force_busy != 0) ? force_busy : nz64()) : 64'h0, oddv);
                // Leave once the minimum dwell has passed and the last two
                // cycles (this one included) were quiet.
                if (k >= MIN_MERGE - 1 && !cur_b && !prev_b) done = 1'b1;
                else if (k == MAX_MERGE) wd = 1'b1;
                prev_b = cur_b;
            end
            if (wd) begin
                tl_abort = 1'b1;
                break;
            end
            if (oddv != 0) begin
                if (tl_grows == MAX_ITER) begin
                    tl_abort = 1'b1;
                    break;
                end
                push(S_GROW, rnd64(), rnd64());
                tl_grows++;
                m++;
            end else begin
                repeat (PEEL) push(S_PEEL, rnd64(), rnd64());
                break;
            end
        end
    endfunction

    // Publish expectations for the current cycle, then advance one clock.
    task automatic cycle(input logic [2:0] stage);
        e_stage = stage;
        e_ready = (stage == S_IDLE) && m_rdy_ok;
        e_rv    = (stage == S_RV);
        e_iter  = ITER_W'(m_iter);
        e_err   = m_err;
        e_cyc   = CYC_EN ? 32'(m_cyc) : 32'd0;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!reset) begin
            m_iter = 0;
            m_err  = 1'b0;
            m_cyc  = 0;
            m_rdy_ok = 1'b0;
        end else begin
            m_rdy_ok = 1'b1;
        end
    endtask

    task automatic idle_cycle();
        meas_valid   = 1'b0;
        busy         = rnd64();
        odd          = rnd64();
        result_ready = 1'($urandom);
        cycle(S_IDLE);
    endtask

    // Observations of the DUT for literal checks after a round.
    int r_len, r_merge, r_grow, r_peel, r_rv;
    logic [ITER_W-1:0] r_iter;
    logic              r_err;
    logic [31:0]       r_cyc;

    task automatic run_round(input int n_odd, input int busy_len0, input bit rand_busy,
                             input bit busy_stuck, input int wait_cycles, input int reset_at,
                             input bit mv_wait);
        build_round(n_odd, busy_len0, rand_busy, busy_stuck);
        r_len = 0; r_merge = 0; r_grow = 0; r_peel = 0; r_rv = 0;
        // Acceptance cycle.
        meas_valid   = 1'b1;
        busy         = rnd64();
        odd          = rnd64();
        result_ready = 1'($urandom);
        cycle(S_IDLE);
        m_iter = 0;
        m_err  = 1'b0;
        m_cyc  = 0;
        for (int t = 0; t < tl.size(); t++) begin
            meas_valid   = 1'($urandom);
            busy         = tl[t].busy;
            odd          = tl[t].odd;
            result_ready = 1'($urandom);
            if (global_stage != S_IDLE && global_stage != S_RV) r_len++;
            if (global_stage == S_MERGE) r_merge++;
            if (global_stage == S_GROW) r_grow++;
            if (global_stage == S_PEEL) r_peel++;
            if (t == reset_at) begin
                reset = 1'b0;
                cycle(tl[t].stage);
                reset = 1'b1;
                return;
            end
            cycle(tl[t].stage);
            if (tl[t].stage == S_GROW) m_iter++;
            m_cyc++;
        end
        m_err = tl_abort;
        for (int w = 0; w <= wait_cycles; w++) begin
            meas_valid   = mv_wait ? 1'b1 : 1'($urandom);
            result_ready = (w == wait_cycles);
            busy         = rnd64();
            odd          = rnd64();
            if (w == 0) begin
                r_iter = iteration_count;
                r_err  = error;
                r_cyc  = cycle_count;
            end
            if (result_valid) r_rv++;
            cycle(S_RV);
        end
        meas_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        meas_valid = 1'b0;
        result_ready = 1'b0;
        busy = '0;
        odd = '0;
        @(posedge clk);
        #1;
        // Reset values right after the first reset edge.
        check("reset_stage", 64'(global_stage), 64'(S_IDLE));
        check("reset_meas_ready", 64'(meas_ready), 64'h0);
        check("reset_result_valid", 64'(result_valid), 64'h0);
        check("reset_iter", 64'(iteration_count), 64'h0);
        check("reset_error", 64'(error), 64'h0);
        check("reset_cycle_count", 64'(cycle_count), 64'h0);
        cycle(S_IDLE);
        reset = 1'b1;
        cycle(S_IDLE);
        idle_cycle();

        // Empty syndrome: LOAD 2 + MERGE 4 + PEELING 8.
        run_round(0, 0, 1'b0, 1'b0, 0, -1, 1'b0);
        check("empty_len", 64'(r_len), 64'd14);
        check("empty_merge", 64'(r_merge), 64'd4);
        check("empty_peel", 64'(r_peel), 64'd8);
        check("empty_iter", 64'(r_iter), 64'd0);
        check("empty_error", 64'(r_err), 64'd0);
        check("empty_cycle_count", 64'(r_cyc), CYC_EN ? 64'd14 : 64'd0);
        idle_cycle();

        // Two iterations: odd through the first two MERGE exits.
        run_round(2, 0, 1'b0, 1'b0, 1, -1, 1'b0);
        check("two_iter_len", 64'(r_len), 64'd24);
        check("two_iter_grow", 64'(r_grow), 64'd2);
        check("two_iter_merge", 64'(r_merge), 64'd12);
        check("two_iter_iter", 64'(r_iter), 64'd2);
        check("two_iter_error", 64'(r_err), 64'd0);

        // Busy extension: busy[5] high for the first 7 MERGE cycles.
        force_busy = 64'h1 << 5;
        run_round(0, 7, 1'b0, 1'b0, 0, -1, 1'b0);
        force_busy = '0;
        check("busy_ext_merge", 64'(r_merge), 64'd9);
        check("busy_ext_len", 64'(r_len), 64'd19);
        idle_cycle();

        // Iteration abort: odd never clears.
        run_round(1000, 0, 1'b0, 1'b0, 0, -1, 1'b0);
        check("abort_grow", 64'(r_grow), 64'(MAX_ITER));
        check("abort_iter", 64'(r_iter), 64'(MAX_ITER));
        check("abort_error", 64'(r_err), 64'd1);
        check("abort_peel", 64'(r_peel), 64'd0);

        // Backpressure: result_ready low 10 cycles, meas_valid pushed meanwhile.
        run_round(1, 3, 1'b0, 1'b0, 10, -1, 1'b1);
        check("bp_rv_cycles", 64'(r_rv), 64'd11);
        check("bp_error_cleared", 64'(r_err), 64'd0);
        check("bp_idle_stage", 64'(global_stage), 64'(S_IDLE));
        check("bp_idle_ready", 64'(meas_ready), 64'd1);
        idle_cycle();

        // MERGE watchdog: busy never drops.
        run_round(0, 0, 1'b0, 1'b1, 2, -1, 1'b0);
        check("wd_merge", 64'(r_merge), 64'(MAX_MERGE + 1));
        check("wd_error", 64'(r_err), 64'd1);
        check("wd_peel", 64'(r_peel), 64'd0);
        idle_cycle();

        // Reset during the second MERGE (iteration_count already 1).
        run_round(3, 0, 1'b0, 1'b0, 0, 8, 1'b0);
        check("rst_stage", 64'(global_stage), 64'(S_IDLE));
        check("rst_meas_ready", 64'(meas_ready), 64'd0);
        check("rst_iter", 64'(iteration_count), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_cycle_count", 64'(cycle_count), 64'd0);
        meas_valid = 1'b1;
        busy = rnd64();
        odd = rnd64();
        cycle(S_IDLE);
        check("rst_ready_after_release", 64'(meas_ready), 64'd1);
        check("rst_not_accepted", 64'(global_stage), 64'(S_IDLE));
        idle_cycle();

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(2, 0)) idle_cycle();
            run_round(int'($urandom_range(4, 0)), int'($urandom_range(10, 0)), 1'b1, 1'b0,
                      int'($urandom_range(3, 0)), -1, 1'b0);
        end
        idle_cycle();

        exp_valid = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uf_stage_controller.md
Name: uf_stage_controller

Overview:
- Global sequencer for the union-find decoder array.
- Drives `global_stage` to every processing unit and consumes their aggregated `busy` and `odd` flags.
- Runs the per-round flow: load measurements, then GROW/MERGE iterations until no odd cluster remains, then peeling, then result handshake.
- Sits between the syndrome input interface and the PE array.

Parameters:
- PU_COUNT, 64, number of processing units whose busy/odd are collected
- STAGE_WIDTH, 3, width of stage code
- MIN_MERGE_CYCLES, 4, minimum cycles held in MERGE (covers PE stage-register and busy-register latency)
- MAX_MERGE_CYCLES, 255, MERGE watchdog limit
- MAX_ITERATIONS, 31, GROW/MERGE iteration limit before abort
- PEEL_CYCLES, 8, fixed cycles held in PEELING
- ITER_WIDTH, 5, width of iteration counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- meas_valid  in  1  syndrome bus valid for a new round
- meas_ready  out  1  controller can accept a round
- busy  in  PU_COUNT  per-PE busy flags
- odd  in  PU_COUNT  per-PE odd-cluster flags
- global_stage  out  STAGE_WIDTH  stage broadcast to all PEs
- result_valid  out  1  round finished, corrections readable
- result_ready  in  1  consumer accepts result
- iteration_count  out  ITER_WIDTH  GROW/MERGE iterations in current/last round
- error  out  1  round aborted (iteration or merge watchdog)
- cycle_count  out  32  round latency (optional feature)

Behaviour:
- Stage codes: IDLE=0, GROW=1, MERGE=2, PEELING=3, RESULT_VALID=4, MEASUREMENT_LOADING=5.
- `global_stage` is a register output equal to the current FSM state.
- Reset (reset==0 at clk edge):
  - `global_stage`=IDLE, `meas_ready`=0, `result_valid`=0, `iteration_count`=0, `error`=0, `cycle_count`=0.
  - All counters clear.
  - Reset mid-round aborts immediately with no result.
- IDLE:
  - `meas_ready`=1.
  - On `meas_valid` & `meas_ready`: go to MEASUREMENT_LOADING; clear `iteration_count`, `error` and merge counter.
- MEASUREMENT_LOADING:
  - Held exactly 2 cycles; PEs see the stage one cycle late.
  - `meas_ready`=0. The source holds measurement data stable until `meas_ready` is seen high again.
  - Then go to MERGE, not GROW, so a clean initial odd is computed.
- MERGE:
  - Merge counter increments each cycle, saturating at MAX_MERGE_CYCLES.
  - Quiet counter counts consecutive cycles with ~|busy and resets on any busy bit.
  - Exit when merge counter ≥ MIN_MERGE_CYCLES−1 and quiet counter ≥ 2.
  - On exit: if |odd then go to GROW, else go to PEELING.
  - Watchdog: if merge counter reaches MAX_MERGE_CYCLES without exit, set `error`=1 and go to RESULT_VALID.
- GROW:
  - Held exactly 1 cycle; the PE increase pulse fires on the stage edge.
  - Increment `iteration_count`, then go to MERGE with merge and quiet counters cleared.
  - If `iteration_count` already equals MAX_ITERATIONS when GROW would be entered, go to RESULT_VALID with `error`=1 instead, and do not increment.
- PEELING:
  - Held exactly PEEL_CYCLES cycles, then go to RESULT_VALID.
- RESULT_VALID:
  - `result_valid`=1, held until `result_ready` is sampled high.
  - Same cycle as acceptance: `result_valid`=0 next cycle, go to IDLE.
  - `iteration_count` and `error` hold their values until the next round is accepted.
- `meas_valid` outside IDLE is ignored; no queuing.
- Simultaneous last quiet cycle and new busy: busy wins, quiet counter resets, MERGE continues.
- X on `busy`/`odd` in non-MERGE states is don't-care; only MERGE samples them.

Optional Feature:
- Macro: UF_CYCLE_COUNTER_EN.
- Defined:
  - `cycle_count` clears on round acceptance and increments each cycle while state ∉ {IDLE, RESULT_VALID}; saturates at 2^32−1.
  - Holds its value through RESULT_VALID and IDLE.
- Undefined: `cycle_count` tied to 0 and no counter logic is synthesized.

Test Plan:
- Empty syndrome: `meas_valid` pulse, `busy`=0, `odd`=0.
  - Required: LOADING 2 cycles, MERGE 4 cycles, PEELING 8 cycles, then RESULT_VALID.
  - `iteration_count`=0, `error`=0, `cycle_count`=14 (macro on).
- Two iterations: `odd` held nonzero through the first two MERGE exits, then 0.
  - Required sequence: LOAD, MERGE, GROW, MERGE, GROW, MERGE, PEELING, RESULT_VALID.
  - `iteration_count`=2.
- Busy extension: busy[5]=1 for the first 7 MERGE cycles.
  - Required: MERGE lasts exactly 9 cycles (2 quiet cycles after busy drops).
- Iteration abort: `odd` stuck high with MAX_ITERATIONS=3.
  - Required: RESULT_VALID after 3 GROWs, `error`=1, `iteration_count`=3, PEELING never entered.
- Backpressure: `result_ready`=0 for 10 cycles, then 1.
  - Required: `result_valid` stable high for 11 cycles, then IDLE with `meas_ready`=1 the next cycle.
  - `meas_valid` during the wait is ignored.
- Reset mid-MERGE: reset=0 for 1 cycle.
  - Required: next cycle `global_stage`=IDLE, all outputs at reset values, `meas_ready`=1 the cycle after reset releases.
